// File: rtl/pe_arr_seq.sv
`default_nettype none
// ============================================================================
// Module   : pe_arr_seq
// Purpose  : Tile sequencer for a ROWS x COLS systolic PE array. For each
//            accepted tile it clears the array, reads K operand rows from the
//            weight/activation buffers, skews every lane by its index so that
//            wavefronts line up inside the array, and asserts fire for the
//            whole interval in which any PE still sees valid data.
// Ports    : clk, rstn            - clock, asynchronous active-low reset
//            start, k_len, abort  - tile request, tile depth K, cancel
//            busy, done           - tile in progress, one-cycle completion
//            out_valid            - array holds a complete tile result
//            rd_en, rd_addr       - operand buffer read strobe / address
//            w_rdata, a_rdata     - buffer read data (1-cycle latency)
//            arr_rstn, fire       - PE array clear (active low) / enable
//            in_w, in_a           - skewed weight / activation lanes
// Revision : 1.0 - initial release
// ============================================================================
module pe_arr_seq #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int KW   = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [KW-1:0]      k_len,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               out_valid,
  output logic               rd_en,
  output logic [KW-1:0]      rd_addr,
  input  logic [COLS*DW-1:0] w_rdata,
  input  logic [ROWS*DW-1:0] a_rdata,
  output logic               arr_rstn,
  output logic               fire,
  output logic [COLS*DW-1:0] in_w,
  output logic [ROWS*DW-1:0] in_a
);

  // After the last read, the final element still has to ripple through the
  // deepest skew lane and across the array diagonal.
  localparam int DRAIN_LEN = ROWS + COLS - 1;
  localparam int DCW       = $clog2(DRAIN_LEN + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state, state_nx;
  logic [KW-1:0]  k_reg;
  logic [KW-1:0]  addr, addr_nx;
  logic [DCW-1:0] dcnt, dcnt_nx;
  logic           accept;
  logic           clear_now;
  logic           ov_reg;
  logic           arr_rel;
  logic           data_vld;
  logic [KW-1:0]  k_last;

  assign accept = (state == IDLE) && start && (k_len != '0) && !abort;
  assign k_last = k_reg - KW'(1);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      addr  <= '0;
      dcnt  <= '0;
      k_reg <= '0;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
      dcnt  <= dcnt_nx;
      if (accept) k_reg <= k_len;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx  = state;
    addr_nx   = addr;
    dcnt_nx   = dcnt;
    busy      = 1'b1;
    done      = 1'b0;
    rd_en     = 1'b0;
    fire      = 1'b0;
    clear_now = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nx = CLEAR;
      end
      CLEAR: begin
        clear_now = 1'b1;
        state_nx  = FEED;
        addr_nx   = '0;
      end
      FEED: begin
        rd_en = 1'b1;
        // F0 only issues the first read; data reaches lane 0 one cycle later.
        fire  = (addr != '0);
        if (addr == k_last) begin
          state_nx = DRAIN;
          addr_nx  = '0;
          dcnt_nx  = '0;
        end else begin
          addr_nx = addr + KW'(1);
        end
      end
      DRAIN: begin
        fire = 1'b1;
        if (dcnt == DCW'(DRAIN_LEN - 1)) begin
          state_nx = DONE;
          dcnt_nx  = '0;
        end else begin
          dcnt_nx = dcnt + DCW'(1);
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase

    if (abort) begin
      state_nx = IDLE;
      addr_nx  = '0;
      dcnt_nx  = '0;
    end
  end

  assign rd_addr = addr;

  // --------------------------------------------------------------------------
  // Result-valid flag, array clear release, read-data valid
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ov_reg   <= 1'b0;
      arr_rel  <= 1'b0;
      data_vld <= 1'b0;
    end else begin
      // arr_rstn is held low through reset and released one edge later.
      arr_rel  <= 1'b1;
      data_vld <= rd_en && !abort;
      if (abort || accept) begin
        ov_reg <= 1'b0;
      end else if ((state == DRAIN) && (state_nx == DONE)) begin
        ov_reg <= 1'b1;
      end
    end
  end

  assign out_valid = ov_reg;
  assign arr_rstn  = arr_rel && !clear_now;

  // --------------------------------------------------------------------------
  // Lane skew: lane n is delayed by n cycles behind the raw read data. The
  // head of every lane is forced to zero whenever no read is returning, so
  // the shift registers only ever carry zeros outside the tile's wavefront.
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < COLS; c++) begin : g_w_lane
    logic [DW-1:0] head;
    assign head = data_vld ? w_rdata[c*DW +: DW] : '0;
    if (c == 0) begin : g_direct
      assign in_w[c*DW +: DW] = head;
    end else begin : g_skew
      logic [DW-1:0] sr [c];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int j = 0; j < c; j++) sr[j] <= '0;
        end else if (abort) begin
          for (int j = 0; j < c; j++) sr[j] <= '0;
        end else begin
          sr[0] <= head;
          for (int j = 1; j < c; j++) sr[j] <= sr[j-1];
        end
      end
      assign in_w[c*DW +: DW] = sr[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_a_lane
    logic [DW-1:0] head;
    assign head = data_vld ? a_rdata[r*DW +: DW] : '0;
    if (r == 0) begin : g_direct
      assign in_a[r*DW +: DW] = head;
    end else begin : g_skew
      logic [DW-1:0] sr [r];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int j = 0; j < r; j++) sr[j] <= '0;
        end else if (abort) begin
          for (int j = 0; j < r; j++) sr[j] <= '0;
        end else begin
          sr[0] <= head;
          for (int j = 1; j < r; j++) sr[j] <= sr[j-1];
        end
      end
      assign in_a[r*DW +: DW] = sr[r-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_arr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_arr_seq
// Purpose  : Self-checking bench for pe_arr_seq. A timeline model derives
//            every output from the tile's start cycle and depth; a small
//            systolic PE array driven by the DUT lanes checks the results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_arr_seq;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int KW   = 8;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               start = 1'b0;
  logic [KW-1:0]      k_len = '0;
  logic               abort = 1'b0;
  logic               busy, done, out_valid, rd_en, arr_rstn, fire;
  logic [KW-1:0]      rd_addr;
  logic [COLS*DW-1:0] w_rdata = '0;
  logic [ROWS*DW-1:0] a_rdata = '0;
  logic [COLS*DW-1:0] in_w;
  logic [ROWS*DW-1:0] in_a;

  always #5 clk = ~clk;

  pe_arr_seq #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .KW(KW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .done(done), .out_valid(out_valid), .rd_en(rd_en),
    .rd_addr(rd_addr), .w_rdata(w_rdata), .a_rdata(a_rdata),
    .arr_rstn(arr_rstn), .fire(fire), .in_w(in_w), .in_a(in_a)
  );

  // Operand buffers: 1-cycle read latency, junk when not reading.
  logic [COLS*DW-1:0] w_mem [256];
  logic [ROWS*DW-1:0] a_mem [256];

  always @(posedge clk) begin
    if (rd_en) begin
      w_rdata <= w_mem[rd_addr];
      a_rdata <= a_mem[rd_addr];
    end else begin
      w_rdata <= '1;
      a_rdata <= '1;
    end
  end

  // Systolic array: activations move right, weights move down.
  int unsigned   acc [ROWS][COLS];
  logic [DW-1:0] ah  [ROWS][COLS];
  logic [DW-1:0] wv  [ROWS][COLS];

  function automatic logic [DW-1:0] a_at(int r, int c);
    if (c == 0) return in_a[r*DW +: DW];
    return ah[r][c-1];
  endfunction

  function automatic logic [DW-1:0] w_at(int r, int c);
    if (r == 0) return in_w[c*DW +: DW];
    return wv[r-1][c];
  endfunction

  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!arr_rstn) begin
          acc[r][c] <= 0;
          ah[r][c]  <= '0;
          wv[r][c]  <= '0;
        end else begin
          ah[r][c] <= a_at(r, c);
          wv[r][c] <= w_at(r, c);
          if (fire) acc[r][c] <= acc[r][c] + 32'(a_at(r, c)) * 32'(w_at(r, c));
        end
      end
    end
  end

  // Bookkeeping
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Timeline model state
  bit m_active = 1'b0;
  bit m_ov = 1'b0;
  bit m_arr_ok = 1'b0;
  int m_t0 = 0;
  int m_k = 0;

  // Observation counters for literal checks
  int busy_cnt, fire_cnt, rden_cnt, done_cnt, last_done_cyc, a3_hits, a3_cyc, max_addr;

  task automatic clear_mon();
    busy_cnt = 0; fire_cnt = 0; rden_cnt = 0; done_cnt = 0;
    last_done_cyc = -1; a3_hits = 0; a3_cyc = -1; max_addr = -1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic longint exp_sum(int r, int c);
    longint s = 0;
    for (int i = 0; i < m_k; i++)
      s += longint'(a_mem[i][r*DW +: DW]) * longint'(w_mem[i][c*DW +: DW]);
    return s;
  endfunction

  task automatic cycle_check();
    int t, d, idx;
    bit e_busy, e_done, e_rd, e_fire, e_arr, e_ov;
    longint e_addr;
    logic [COLS*DW-1:0] e_w;
    logic [ROWS*DW-1:0] e_a;
    t = cyc - m_t0;
    d = m_k + ROWS + COLS + 1;
    e_w = '0;
    e_a = '0;
    if (!rstn) begin
      e_busy = 0; e_done = 0; e_rd = 0; e_fire = 0; e_arr = 0; e_ov = 0; e_addr = 0;
    end else begin
      e_busy = m_active;
      e_done = m_active && (t == d);
      e_rd   = m_active && (t >= 2) && (t <= m_k + 1);
      e_addr = e_rd ? longint'(t - 2) : 0;
      e_fire = m_active && (t >= 3) && (t <= m_k + ROWS + COLS);
      e_arr  = m_arr_ok && !(m_active && (t == 1));
      e_ov   = m_active ? (t == d) : m_ov;
      if (m_active) begin
        for (int c = 0; c < COLS; c++) begin
          idx = t - 3 - c;
          if (idx >= 0 && idx < m_k) e_w[c*DW +: DW] = w_mem[idx][c*DW +: DW];
        end
        for (int r = 0; r < ROWS; r++) begin
          idx = t - 3 - r;
          if (idx >= 0 && idx < m_k) e_a[r*DW +: DW] = a_mem[idx][r*DW +: DW];
        end
      end
    end
    chk("busy", longint'(busy), longint'(e_busy));
    chk("done", longint'(done), longint'(e_done));
    chk("rd_en", longint'(rd_en), longint'(e_rd));
    chk("rd_addr", longint'(rd_addr), e_addr);
    chk("fire", longint'(fire), longint'(e_fire));
    chk("arr_rstn", longint'(arr_rstn), longint'(e_arr));
    chk("out_valid", longint'(out_valid), longint'(e_ov));
    chk("in_w", longint'(in_w), longint'(e_w));
    chk("in_a", longint'(in_a), longint'(e_a));
    if (rstn && m_active && t == d) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          chk("pe_acc", longint'(acc[r][c]), exp_sum(r, c));
    end

    if (busy) busy_cnt++;
    if (fire) fire_cnt++;
    if (rd_en) begin
      rden_cnt++;
      if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
    end
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (in_a[3*DW +: DW] != '0) begin
      a3_hits++;
      a3_cyc = cyc;
    end

    // Advance the model to the next cycle.
    if (!rstn) begin
      m_active = 0; m_ov = 0; m_arr_ok = 0;
    end else begin
      m_arr_ok = 1;
      if (abort) begin
        m_active = 0; m_ov = 0;
      end else if (m_active) begin
        if (t == d) begin
          m_active = 0; m_ov = 1;
        end
      end else if (start && k_len != '0) begin
        m_active = 1; m_t0 = cyc; m_k = int'(k_len); m_ov = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic start_tile(input int k, output int s);
    s = cyc;
    start = 1'b1;
    k_len = KW'(k);
    tick();
    start = 1'b0;
    k_len = '0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == n0; i++) tick();
    chk("done_seen", longint'(done_cnt - n0), 1);
  endtask

  task automatic fill(input int k, input bit rnd, input logic [DW-1:0] v);
    for (int i = 0; i < k; i++) begin
      if (rnd) begin
        w_mem[i] = $urandom();
        a_mem[i] = $urandom();
      end else begin
        w_mem[i] = {COLS{v}};
        a_mem[i] = {ROWS{v}};
      end
    end
  endtask

  initial begin
    int s;
    clear_mon();

    // Reset state
    repeat (2) tick();
    chk("rst_arr_rstn", longint'(arr_rstn), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_in_w", longint'(in_w), 0);
    rstn = 1'b1;
    tick();
    chk("arr_rstn_release", longint'(arr_rstn), 1);
    repeat (2) tick();

    // K=4, all ones
    fill(4, 0, 8'd1);
    clear_mon();
    start_tile(4, s);
    wait_done(40);
    chk("k4_done_t", longint'(last_done_cyc - s), 13);
    chk("k4_busy_cycles", longint'(busy_cnt), 13);
    chk("k4_fire_cycles", longint'(fire_cnt), 10);
    chk("k4_rd_cycles", longint'(rden_cnt), 4);
    chk("k4_pe00", longint'(acc[0][0]), 4);
    chk("k4_pe33", longint'(acc[3][3]), 4);
    tick();
    chk("k4_out_valid_hold", longint'(out_valid), 1);

    // K=1, a=w=3
    fill(1, 0, 8'd3);
    clear_mon();
    start_tile(1, s);
    wait_done(40);
    chk("k1_done_t", longint'(last_done_cyc - s), 10);
    chk("k1_fire_cycles", longint'(fire_cnt), 7);
    chk("k1_a3_hits", longint'(a3_hits), 1);
    chk("k1_a3_cycle", longint'(a3_cyc - s), 6);
    chk("k1_pe32", longint'(acc[3][2]), 9);
    repeat (2) tick();

    // start while busy is ignored
    fill(4, 1, '0);
    clear_mon();
    start_tile(4, s);
    repeat (4) tick();
    start = 1'b1;
    k_len = KW'(4);
    tick();
    start = 1'b0;
    k_len = '0;
    wait_done(40);
    chk("busy_start_done_t", longint'(last_done_cyc - s), 13);
    repeat (20) tick();
    chk("busy_start_one_done", longint'(done_cnt), 1);
    chk("busy_start_busy_cycles", longint'(busy_cnt), 13);
    fill(3, 1, '0);
    clear_mon();
    start_tile(3, s);
    wait_done(40);
    chk("k3_done_t", longint'(last_done_cyc - s), 12);
    repeat (2) tick();

    // abort mid-tile
    fill(4, 1, '0);
    clear_mon();
    start_tile(4, s);
    repeat (6) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_fire", longint'(fire), 0);
    chk("abort_in_w", longint'(in_w), 0);
    chk("abort_in_a", longint'(in_a), 0);
    chk("abort_out_valid", longint'(out_valid), 0);
    repeat (15) tick();
    chk("abort_no_done", longint'(done_cnt), 0);

    // abort and start together in IDLE
    clear_mon();
    abort = 1'b1;
    start = 1'b1;
    k_len = KW'(4);
    tick();
    abort = 1'b0;
    start = 1'b0;
    k_len = '0;
    repeat (4) tick();
    chk("abort_start_no_busy", longint'(busy_cnt), 0);

    // reset pulse mid-tile
    fill(4, 0, 8'd1);
    clear_mon();
    start_tile(4, s);
    repeat (8) tick();
    #1 rstn = 1'b0;
    #1;
    chk("rst_mid_busy", longint'(busy), 0);
    chk("rst_mid_fire", longint'(fire), 0);
    chk("rst_mid_arr_rstn", longint'(arr_rstn), 0);
    chk("rst_mid_lanes", longint'(in_w | in_a), 0);
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    chk("rst_mid_no_done", longint'(done_cnt), 0);
    fill(2, 1, '0);
    clear_mon();
    start_tile(2, s);
    wait_done(40);
    chk("k2_done_t", longint'(last_done_cyc - s), 11);
    repeat (2) tick();

    // k_len = 0 is ignored
    clear_mon();
    start = 1'b1;
    k_len = '0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("k0_busy", longint'(busy_cnt), 0);
    chk("k0_rd", longint'(rden_cnt), 0);
    chk("k0_done", longint'(done_cnt), 0);

    // maximum depth, no address wrap
    fill(255, 1, '0);
    clear_mon();
    start_tile(255, s);
    wait_done(400);
    chk("kmax_done_t", longint'(last_done_cyc - s), 264);
    chk("kmax_rd_cycles", longint'(rden_cnt), 255);
    chk("kmax_max_addr", longint'(max_addr), 254);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_arr_seq.md
PE_ARR_SEQ -- requirements
Module: pe_arr_seq

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning PE array row count (activation lanes).
REQ-002 SHALL have parameter COLS, default 4, meaning PE array column count (weight lanes).
REQ-003 SHALL have parameter DW, default 8, meaning element width.
REQ-004 SHALL have parameter KW, default 8, meaning width of tile-length and address fields.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rstn, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit, request to run one tile.
REQ-008 SHALL have port k_len, input, KW bits, tile depth K, sampled with start.
REQ-009 SHALL have port abort, input, 1 bit, cancel the tile in progress.
REQ-010 SHALL have port busy, output, 1 bit, tile in progress.
REQ-011 SHALL have port done, output, 1 bit, one-cycle tile-complete pulse.
REQ-012 SHALL have port out_valid, output, 1 bit, array outputs hold a complete tile result.
REQ-013 SHALL have ports rd_en (output, 1 bit) and rd_addr (output, KW bits), the operand buffer read strobe and address.
REQ-014 SHALL have ports w_rdata (input, COLS*DW bits) and a_rdata (input, ROWS*DW bits), buffer read data with a fixed latency of 1 cycle.
REQ-015 SHALL have ports arr_rstn, fire (outputs, 1 bit each), in_w (output, COLS*DW bits) and in_a (output, ROWS*DW bits), which drive the PE array.

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-017 IDLE: start=1 with k_len!=0 SHALL latch k_len into K and go to CLEAR; start with k_len=0 SHALL be ignored.
REQ-018 CLEAR (1 cycle): arr_rstn=0 and out_valid cleared; next state FEED.
REQ-019 FEED (K cycles, F0..F(K-1)): rd_en=1 and rd_addr=0..K-1 incrementing by 1 per cycle; next state DRAIN.
REQ-020 Skew: the lane-c slice of w_rdata returned for address i SHALL appear on in_w[c] at cycle F(i+1+c); a_rdata lane r SHALL appear on in_a[r] at cycle F(i+1+r).
REQ-021 Every lane SHALL carry 0 in any cycle with no valid skewed element.
REQ-022 fire SHALL be 1 from F1 for exactly K+ROWS+COLS-2 consecutive cycles, and 0 otherwise.
REQ-023 DRAIN SHALL last until the last fire cycle has passed, then go to DONE.
REQ-024 DONE (1 cycle): done=1 and out_valid is set; next state IDLE.
REQ-025 out_valid SHALL remain 1 until the next CLEAR, abort or reset.
REQ-026 busy SHALL be 1 in CLEAR, FEED, DRAIN and DONE.
REQ-027 start while busy=1 SHALL be ignored and SHALL NOT queue.
REQ-028 abort while busy=1 SHALL force IDLE on the next edge, with fire=0, rd_en=0, all skew registers zeroed, no done pulse and out_valid=0; abort has priority over every transition, including DONE.
REQ-029 abort and start in the same IDLE cycle: abort wins and start is ignored.
REQ-030 rd_addr SHALL be a KW-bit counter; K=2^KW-1 SHALL read addresses 0..2^KW-2 with no wrap.
REQ-031 arr_rstn SHALL be 1 in every state except CLEAR and reset.

Reset
REQ-032 While rstn=0: state IDLE; busy, done, out_valid, rd_en, fire and arr_rstn are 0; rd_addr=0; in_w, in_a and all skew registers are 0.
REQ-033 After rstn deasserts, arr_rstn SHALL return to 1 at the first clk edge.
REQ-034 Reset asserted mid-tile SHALL take effect immediately (asynchronous) with no done pulse.

Verification (ROWS=COLS=4, DW=8; start accepted at cycle 0)
REQ-035 K=4, buffer rows all 1 -> CLEAR at cycle 1; rd_addr 0,1,2,3 at cycles 2-5; fire=1 at cycles 3-12; done at cycle 13; busy at cycles 1-13; array outs all 4.
REQ-036 K=1, a=w=3 -> fire for 7 cycles; in_a[3] is 3 only at cycle 6 and 0 at all other cycles; done at cycle 10.
REQ-037 start pulsed at cycle 5 of a K=4 tile -> ignored: single done at cycle 13, and a second start after done runs normally.
REQ-038 abort at cycle 7 of a K=4 tile -> IDLE at cycle 8 with fire=0, lanes zeroed, no done, out_valid=0.
REQ-039 rstn pulsed low at cycle 9 of a K=4 tile -> all outputs 0 immediately; a new start then completes correctly.
REQ-040 start with k_len=0 -> no busy, no rd_en, no done; the FSM stays in IDLE.
